// File: rtl/fpnew_pkg.sv
// Shared FPU result-path types and helpers used by the result reorder stage.
package fpnew_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  localparam int unsigned NUM_OPGROUPS = 5;

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int unsigned order_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fpnew_order_fifo.sv
// Circular FIFO of channel IDs recording issue order, with an empty-FIFO
// bypass so a zero-latency channel can retire in its issue cycle.
module fpnew_order_fifo
  import fpnew_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned CW    = 3,
  localparam int unsigned PW   = $clog2(Depth),
  localparam int unsigned CNTW = order_cnt_width(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            bypass_en_i,
  input  logic            push_i,
  input  logic [CW-1:0]   push_chan_i,
  input  logic            pop_i,
  output logic [CW-1:0]   head_o,
  output logic            head_valid_o,
  output logic            full_o,
  output logic [CNTW-1:0] count_o
);

  logic [CW-1:0]   mem_q [Depth];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            empty, do_push, do_pop, cancel;

  assign empty        = (count_q == '0);
  assign full_o       = (count_q == CNTW'(Depth));
  assign head_valid_o = !empty || (bypass_en_i && push_i);
  assign head_o       = empty ? push_chan_i : mem_q[rd_ptr_q];
  assign count_o      = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && head_valid_o;
  // A record pushed and retired in the same cycle never touches storage.
  assign cancel  = empty && do_push && do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (!cancel) begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !cancel) mem_q[wr_ptr_q] <= push_chan_i;
  end

endmodule

// File: rtl/fpnew_result_reorder.sv
// FPU result arbitration: retires opgroup results in issue order (InOrder=1)
// or by round-robin among valid channels (InOrder=0).
module fpnew_result_reorder
  import fpnew_pkg::*;
#(
  parameter int unsigned Width       = 64,
  parameter int unsigned NumChannels = NUM_OPGROUPS,
  parameter int unsigned Depth       = 8,
  parameter bit          InOrder     = 1'b1,
  parameter type         TagType     = logic,
  localparam int unsigned CW         = $clog2(NumChannels),
  localparam int unsigned CNTW       = order_cnt_width(Depth)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                issue_valid_i,
  input  logic [CW-1:0]                       issue_chan_i,
  output logic                                issue_ready_o,
  input  logic [NumChannels-1:0]              chan_valid_i,
  output logic [NumChannels-1:0]              chan_ready_o,
  input  logic [NumChannels-1:0][Width-1:0]   chan_result_i,
  input  status_t [NumChannels-1:0]           chan_status_i,
  input  TagType [NumChannels-1:0]            chan_tag_i,
  output logic [Width-1:0]                    result_o,
  output status_t                             status_o,
  output TagType                              tag_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [CNTW-1:0]                     occupancy_o,
  output logic                                busy_o
);

  if (NumChannels < 2 || NumChannels > 16) begin : g_bad_channels
    $error("NumChannels must be in 2..16");
  end
  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("Depth must be a power of two, at least 2");
  end

  // Handshakes: a transfer happens on a rising clk_i edge where valid and
  // ready are both high; valid never waits for ready, and a producer holding
  // valid keeps its data stable until the transfer.
  logic [CW-1:0]    sel;
  logic             sel_present;
  logic             sel_chan_valid;
  logic [Width-1:0] sel_result;
  status_t          sel_status;
  TagType           sel_tag;
  logic             handshake;

  always_comb begin
    sel_chan_valid = 1'b0;
    sel_result     = '0;
    sel_status     = '0;
    sel_tag        = '0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      if (sel == CW'(i)) begin
        sel_chan_valid = chan_valid_i[i];
        sel_result     = chan_result_i[i];
        sel_status     = chan_status_i[i];
        sel_tag        = chan_tag_i[i];
      end
    end
  end

  // Outputs are gated by rst_i so an asynchronous reset silences them at once.
  assign out_valid_o = !rst_i && sel_present && sel_chan_valid;
  assign handshake   = out_valid_o && out_ready_i;
  assign result_o    = sel_result;
  assign status_o    = sel_status;
  assign tag_o       = sel_tag;
  assign busy_o      = (occupancy_o != '0) || (|chan_valid_i);

  always_comb begin
    chan_ready_o = '0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      chan_ready_o[i] = !rst_i && sel_present && out_ready_i && (sel == CW'(i));
    end
  end

  if (InOrder) begin : g_ordered
    logic            fifo_full;
    logic [CNTW-1:0] fifo_count;

    assign issue_ready_o = !fifo_full;
    assign occupancy_o   = fifo_count;

    fpnew_order_fifo #(
      .Depth (Depth),
      .CW    (CW)
    ) i_order_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .bypass_en_i  (1'b1),
      .push_i       (issue_valid_i && issue_ready_o),
      .push_chan_i  (issue_chan_i),
      .pop_i        (handshake),
      .head_o       (sel),
      .head_valid_o (sel_present),
      .full_o       (fifo_full),
      .count_o      (fifo_count)
    );

`ifndef SYNTHESIS
    a_valid_has_record: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
      (|chan_valid_i) |-> (fifo_count != '0 || (issue_valid_i && issue_ready_o)))
      else $error("channel result valid with no order record held");
`endif
  end else begin : g_round_robin
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] lock_chan_q, lock_chan_d;
    logic          lock_q, lock_d;
    logic [CW-1:0] winner;
    int            idx;

    assign issue_ready_o = 1'b1;
    assign occupancy_o   = '0;

    // Scan downward so the lowest offset from rr_ptr_q is the last to win.
    always_comb begin
      winner = rr_ptr_q;
      idx    = 0;
      for (int off = int'(NumChannels) - 1; off >= 0; off--) begin
        idx = (int'(rr_ptr_q) + off) % int'(NumChannels);
        if (chan_valid_i[idx]) winner = CW'(idx);
      end
    end

    assign sel         = lock_q ? lock_chan_q : winner;
    assign sel_present = lock_q || (|chan_valid_i);

    always_comb begin
      rr_ptr_d    = rr_ptr_q;
      lock_d      = lock_q;
      lock_chan_d = lock_chan_q;
      if (flush_i) begin
        rr_ptr_d    = '0;
        lock_d      = 1'b0;
        lock_chan_d = '0;
      end else if (handshake) begin
        rr_ptr_d = (sel == CW'(NumChannels - 1)) ? '0 : sel + 1'b1;
        lock_d   = 1'b0;
      end else if (out_valid_o) begin
        lock_d      = 1'b1;
        lock_chan_d = sel;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rr_ptr_q    <= '0;
        lock_q      <= 1'b0;
        lock_chan_q <= '0;
      end else begin
        rr_ptr_q    <= rr_ptr_d;
        lock_q      <= lock_d;
        lock_chan_q <= lock_chan_d;
      end
    end
  end

`ifndef SYNTHESIS
  a_issue_chan_range: assert property (@(posedge clk_i) disable iff (rst_i)
    issue_valid_i |-> (32'(issue_chan_i) < NumChannels))
    else $error("issue_chan_i out of range");

  a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    (out_valid_o && !out_ready_i) |=> ($stable(result_o) && $stable(status_o) && $stable(tag_o)))
    else $error("output data changed while stalled");
`endif

endmodule

// File: doc/fpnew_result_reorder.md
Name: fpnew_result_reorder

Overview:
- Parametrised successor to the FPU top-level output arbitration stage.
- Collects results from NumChannels operation-group channels.
- In ordered mode, retires results strictly in issue order using an internal FIFO of channel IDs. In legacy mode, falls back to a round-robin stream arbiter.
- Sits between the opgroup blocks and the FPU result port. Ordered mode lets the core drop its own reorder tracking.

Parameters:
- Width, 64, result data width in bits
- NumChannels, 5, number of result channels (fpnew_pkg::NUM_OPGROUPS); must be 2..16
- Depth, 8, in-flight order-record capacity; power of 2, at least 2
- InOrder, 1'b1, 1 = program-order retirement, 0 = round-robin arbitration
- TagType, logic, type of the per-operation tag

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  discard all in-flight order records
- issue_valid_i  in  1  an operation is accepted by channel issue_chan_i this cycle
- issue_chan_i  in  CW=$clog2(NumChannels)  channel the operation was issued to
- issue_ready_o  out  1  order FIFO can record an issue
- chan_valid_i  in  NumChannels  per-channel result valid
- chan_ready_o  out  NumChannels  per-channel result ready
- chan_result_i  in  NumChannels x Width  per-channel result
- chan_status_i  in  NumChannels x 5  per-channel fpnew_pkg::status_t
- chan_tag_i  in  NumChannels x TagType  per-channel tag
- result_o  out  Width  selected result
- status_o  out  5  selected status
- tag_o  out  TagType  selected tag
- out_valid_o  out  1  output valid
- out_ready_i  in  1  output ready
- occupancy_o  out  $clog2(Depth)+1  records held (0 when InOrder=0)
- busy_o  out  1  occupancy_o != 0 OR any chan_valid_i

Behaviour:
- Reset (async, rst_i=1): read/write pointers cleared, count 0, round-robin pointer 0.
  - Resulting outputs: out_valid_o=0, chan_ready_o=0, occupancy_o=0, issue_ready_o=1.
- InOrder=1, push side:
  - issue_ready_o = (count != Depth).
  - Push on issue_valid_i && issue_ready_o; the record is the channel ID.
  - Write pointer increments modulo Depth.
- InOrder=1, head selection:
  - head = FIFO[rd_ptr] when count != 0.
  - When count = 0 and a push occurs this cycle, head = issue_chan_i (same-cycle bypass for zero-latency channels).
  - Otherwise there is no head.
- InOrder=1, output:
  - out_valid_o = head exists && chan_valid_i[head].
  - result_o/status_o/tag_o are driven from channel head, combinationally (zero latency).
  - chan_ready_o[head] = out_ready_i && head exists; all other bits are 0.
- InOrder=1, pop: on out_valid_o && out_ready_i.
  - In the bypass case, push and pop cancel and the count stays 0.
  - Otherwise the read pointer increments modulo Depth.
- InOrder=1, count update:
  - Simultaneous push and pop with 0 < count < Depth: count unchanged.
  - When full, issue_ready_o=0, so a same-cycle pop does not enable a push. There is no full-bypass; the push waits one cycle.
- Non-head valid channels are back-pressured indefinitely (ready=0).
- Flush: on a clock edge with flush_i=1, pointers and count go to 0.
  - Flush has priority over push and pop in that cycle.
  - Output handshakes in the flush cycle still complete combinationally, but have no effect on state.
- InOrder=0 (legacy round-robin):
  - issue_ready_o=1; occupancy_o=0; the FIFO is not instantiated.
  - Winner = first valid channel at or after rr_ptr, wrapping modulo NumChannels.
  - out_valid_o = |chan_valid_i; chan_ready_o[winner] = out_ready_i.
  - On handshake, rr_ptr <= winner+1, modulo NumChannels.
  - While out_valid_o && !out_ready_i, the selection is held stable (lock register).
  - flush_i clears the lock and rr_ptr.
- Protocol assertions (simulation only):
  - chan_valid_i without a matching record.
  - issue_chan_i >= NumChannels.
  - Output data changing while out_valid_o && !out_ready_i.

Decomposition:
- fpnew_pkg: status_t, NUM_OPGROUPS, and a new function order_cnt_width(Depth).
- One sub-module: fpnew_order_fifo, a Depth x CW circular FIFO with:
  - push, pop and flush inputs;
  - head and count outputs;
  - an empty-bypass input.
- The round-robin path stays inline in fpnew_result_reorder.

Test Plan:
- In-order retirement (InOrder=1, Depth=8): issue ch2 then ch0; ch0 result (tag 5) valid in cycle 3, ch2 result (tag 7) valid in cycle 6.
  - Expect out_valid_o=0 until cycle 6, then tag 7, then tag 5.
  - chan_ready_o[0]=0 throughout cycles 3..6.
- Zero-latency bypass: empty FIFO; issue ch1 and ch1 valid in the same cycle with out_ready_i=1.
  - Expect out_valid_o=1 and chan_ready_o=5'b00010 that cycle.
  - occupancy_o stays 0.
- Full/wrap: 8 issues to ch3 with no results; 9th issue attempt.
  - Expect issue_ready_o=0 and occupancy_o=8.
  - Drain all 8 results, then issue 8 more: pointers wrap and results come out in order.
- Back-pressure: head valid with out_ready_i=0 for 4 cycles.
  - Expect result_o/tag_o stable, occupancy_o unchanged, then a single pop.
- Flush mid-operation: 3 records held; flush_i pulse while issue_valid_i=1.
  - Expect occupancy_o=0 next cycle, the concurrent issue discarded, busy_o=0 once no channel is valid.
- Legacy RR with async reset (InOrder=0): ch0 and ch2 continuously valid.
  - Expect alternating grants 0,2,0,2.
  - Assert rst_i mid-stream: out_valid_o drops immediately (async), rr_ptr=0, first grant after release is ch0.
